// File: rtl/cmm_hst2apb_pkg.sv
// rtl/cmm_hst2apb_pkg.sv - shared types and constants for the host-to-APB requester
package cmm_hst2apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // Response classification codes used by scoreboards
   localparam logic [1:0] RSP_OK     = 2'd0;
   localparam logic [1:0] RSP_SLVERR = 2'd1;
   localparam logic [1:0] RSP_TMO    = 2'd2;

   localparam logic [3:0] STRB_ALL = 4'hF;

endpackage

// File: rtl/cmm_tmo_cnt.sv
// rtl/cmm_tmo_cnt.sv - clear/increment wait counter that flags the cycle it reaches its limit
module cmm_tmo_cnt #(
   parameter int C_MAX = 255,
   parameter int C_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   // hit fires on the increment that brings the count to C_MAX; C_MAX of 0 never hits
   localparam logic [C_W-1:0] LAST = C_W'((C_MAX == 0) ? 0 : C_MAX - 1);

   logic [C_W-1:0] cnt;

   // Count increments; clear has priority so a fresh wait window always starts at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + C_W'(1);
      end
   end

   assign hit = (C_MAX != 0) && inc && (cnt == LAST);

endmodule

// File: rtl/cmm_hst2apb.sv
// rtl/cmm_hst2apb.sv - valid/ready host request to APB4 requester with wait-state timeout
module cmm_hst2apb
   import cmm_hst2apb_pkg::*;
#(
   parameter int         C_AW    = 6,
   parameter int         C_TMO   = 255,
   parameter int         C_TMO_W = 8,
   parameter logic [2:0] C_PROT  = 3'b000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_vld,
   output logic            req_rdy,
   input  logic            req_wen,
   input  logic [C_AW-1:0] req_addr,
   input  logic [31:0]     req_wdat,
   input  logic [3:0]      req_strb,
   output logic            rsp_vld,
   output logic [31:0]     rsp_rdat,
   output logic            rsp_err,
   output logic            rsp_tmo,
   output logic            apb_psel,
   output logic            apb_penable,
   output logic            apb_pwrite,
   output logic [2:0]      apb_pprot,
   output logic [C_AW-1:0] apb_paddr,
   output logic [31:0]     apb_pwdata,
   output logic [3:0]      apb_pwstrb,
   input  logic            apb_pready,
   input  logic [31:0]     apb_prdata,
   input  logic            apb_pslverr
);

   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   tmo_clr;
   logic   tmo_inc;
   logic   tmo_hit;

   assign req_rdy   = (state == IDLE);
   assign accept    = req_vld & req_rdy;
   assign apb_pprot = C_PROT;

   cmm_tmo_cnt #(
      .C_MAX (C_TMO),
      .C_W   (C_TMO_W)
   ) u_tmo_cnt (
      .clk (clk),
      .rst (rst),
      .clr (tmo_clr),
      .inc (tmo_inc),
      .hit (tmo_hit)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and timeout counter control; SETUP clears the counter for the coming ACCESS
   always_comb begin
      state_nxt = state;
      tmo_clr   = 1'b0;
      tmo_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = SETUP;
         end
         SETUP: begin
            tmo_clr   = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            if (apb_pready) begin
               state_nxt = IDLE;
            end else begin
               tmo_inc = 1'b1;
               if (tmo_hit) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // APB request signals: select/enable follow the next state, transfer fields latch on acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         apb_psel    <= 1'b0;
         apb_penable <= 1'b0;
         apb_pwrite  <= 1'b0;
         apb_paddr   <= '0;
         apb_pwdata  <= '0;
         apb_pwstrb  <= '0;
      end else begin
         apb_psel    <= (state_nxt != IDLE);
         apb_penable <= (state_nxt == ACCESS);
         if (accept) begin
            apb_pwrite <= req_wen;
            apb_paddr  <= req_addr;
            apb_pwdata <= req_wen ? req_wdat : 32'h0;
            apb_pwstrb <= req_wen ? req_strb : 4'h0;
         end
      end
   end

   // One-cycle response; normal completion takes precedence over a same-cycle timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_vld  <= 1'b0;
         rsp_rdat <= 32'h0;
         rsp_err  <= 1'b0;
         rsp_tmo  <= 1'b0;
      end else begin
         rsp_vld  <= 1'b0;
         rsp_rdat <= 32'h0;
         rsp_err  <= 1'b0;
         rsp_tmo  <= 1'b0;
         if (state == ACCESS) begin
            if (apb_pready) begin
               rsp_vld  <= 1'b1;
               rsp_err  <= apb_pslverr;
               rsp_rdat <= apb_pwrite ? 32'h0 : apb_prdata;
            end else if (tmo_hit) begin
               rsp_vld <= 1'b1;
               rsp_err <= 1'b1;
               rsp_tmo <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cmm_hst2apb.sv
// tb/tb_cmm_hst2apb.sv - self-checking bench for the host-to-APB requester
module tb_cmm_hst2apb;
   import cmm_hst2apb_pkg::*;

   localparam int         AW   = 6;
   localparam int         TMO  = 4;
   localparam logic [2:0] PROT = 3'b010;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_vld = 1'b0;
   logic          req_rdy;
   logic          req_wen = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_wdat = '0;
   logic [3:0]    req_strb = '0;
   logic          rsp_vld;
   logic [31:0]   rsp_rdat;
   logic          rsp_err;
   logic          rsp_tmo;
   logic          apb_psel;
   logic          apb_penable;
   logic          apb_pwrite;
   logic [2:0]    apb_pprot;
   logic [AW-1:0] apb_paddr;
   logic [31:0]   apb_pwdata;
   logic [3:0]    apb_pwstrb;
   logic          apb_pready = 1'b0;
   logic [31:0]   apb_prdata = '0;
   logic          apb_pslverr = 1'b0;

   always #5 clk = ~clk;

   cmm_hst2apb #(
      .C_AW    (AW),
      .C_TMO   (TMO),
      .C_TMO_W (8),
      .C_PROT  (PROT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_vld     (req_vld),
      .req_rdy     (req_rdy),
      .req_wen     (req_wen),
      .req_addr    (req_addr),
      .req_wdat    (req_wdat),
      .req_strb    (req_strb),
      .rsp_vld     (rsp_vld),
      .rsp_rdat    (rsp_rdat),
      .rsp_err     (rsp_err),
      .rsp_tmo     (rsp_tmo),
      .apb_psel    (apb_psel),
      .apb_penable (apb_penable),
      .apb_pwrite  (apb_pwrite),
      .apb_pprot   (apb_pprot),
      .apb_paddr   (apb_paddr),
      .apb_pwdata  (apb_pwdata),
      .apb_pwstrb  (apb_pwstrb),
      .apb_pready  (apb_pready),
      .apb_prdata  (apb_prdata),
      .apb_pslverr (apb_pslverr)
   );

   // waits: pready-low ACCESS cycles the completer inserts; lat: cycles from accept to response
   typedef struct {
      logic          wen;
      logic [AW-1:0] addr;
      logic [31:0]   wdat;
      logic [3:0]    strb;
      int            waits;
      logic          err;
      logic [31:0]   rdat;
      int            lat;
      logic          e_err;
      logic          e_tmo;
      logic [31:0]   e_rdat;
   } xfer_t;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   function automatic xfer_t mk(input logic wen, input logic [AW-1:0] addr, input logic [31:0] wdat,
                                input logic [3:0] strb, input int waits, input logic err,
                                input logic [31:0] rdat, input int lat, input logic e_err,
                                input logic e_tmo, input logic [31:0] e_rdat);
      xfer_t r;
      r.wen = wen; r.addr = addr; r.wdat = wdat; r.strb = strb; r.waits = waits;
      r.err = err; r.rdat = rdat; r.lat = lat; r.e_err = e_err; r.e_tmo = e_tmo; r.e_rdat = e_rdat;
      return r;
   endfunction

   // Reference model: a completer that stalls at least TMO cycles loses to the timeout
   function automatic xfer_t model(input xfer_t x);
      xfer_t r = x;
      if (x.waits >= TMO) begin
         r.lat = 2 + TMO; r.e_err = 1'b1; r.e_tmo = 1'b1; r.e_rdat = 32'h0;
      end else begin
         r.lat = 3 + x.waits; r.e_err = x.err; r.e_tmo = 1'b0;
         r.e_rdat = x.wen ? 32'h0 : x.rdat;
      end
      return r;
   endfunction

   // Drive one request from the current negedge and follow it to the response cycle
   task automatic do_xfer(input xfer_t x, input bit hold, input string tag);
      logic [31:0] e_wd;
      logic [3:0]  e_st;
      e_wd = x.wen ? x.wdat : 32'h0;
      e_st = x.wen ? x.strb : 4'h0;
      chk({tag, ".rdy"}, req_rdy, 1'b1);
      req_vld = 1'b1; req_wen = x.wen; req_addr = x.addr; req_wdat = x.wdat; req_strb = x.strb;
      @(negedge clk);
      if (!hold) begin
         req_vld = 1'b0; req_wen = 1'($urandom); req_addr = AW'($urandom);
         req_wdat = $urandom; req_strb = 4'($urandom);
      end
      chk({tag, ".setup"}, {apb_psel, apb_penable, rsp_vld, req_rdy}, 4'b1000);
      apb_pready = 1'($urandom); apb_prdata = $urandom; apb_pslverr = 1'($urandom);
      for (int cyc = 2; cyc <= x.lat; cyc++) begin
         @(negedge clk);
         if (cyc < x.lat) begin
            chk($sformatf("%s.acc%0d.ctl", tag, cyc), {apb_psel, apb_penable, rsp_vld, apb_pwrite},
                {3'b110, x.wen});
            chk($sformatf("%s.acc%0d.addr", tag, cyc), apb_paddr, x.addr);
            chk($sformatf("%s.acc%0d.wdat", tag, cyc), apb_pwdata, e_wd);
            chk($sformatf("%s.acc%0d.strb", tag, cyc), apb_pwstrb, e_st);
            apb_pready  = (cyc - 1 == x.waits + 1);
            apb_prdata  = apb_pready ? x.rdat : $urandom;
            apb_pslverr = apb_pready ? x.err : 1'($urandom);
         end else begin
            chk({tag, ".rsp_ctl"}, {rsp_vld, apb_psel, apb_penable, req_rdy}, 4'b1001);
            chk({tag, ".rsp_err"}, rsp_err, x.e_err);
            chk({tag, ".rsp_tmo"}, rsp_tmo, x.e_tmo);
            chk({tag, ".rsp_rdat"}, rsp_rdat, x.e_rdat);
            apb_pready = 1'b0;
         end
      end
   endtask

   xfer_t tbl[8];
   xfer_t x;

   initial begin
      tbl[0] = mk(1, 6'h04, 32'h0000_0001, STRB_ALL, 0,   0, 32'h0,         3, 0, 0, 32'h0);
      tbl[1] = mk(0, 6'h10, 32'h0,         4'h0,     3,   0, 32'h0000_00A5, 6, 0, 0, 32'h0000_00A5);
      tbl[2] = mk(0, 6'h3F, 32'h0,         4'h0,     0,   1, 32'hDEAD_BEEF, 3, 1, 0, 32'hDEAD_BEEF);
      tbl[3] = mk(0, 6'h08, 32'h0,         4'h0,     200, 0, 32'h1111_1111, 6, 1, 1, 32'h0);
      tbl[4] = mk(0, 6'h08, 32'h0,         4'h0,     0,   0, 32'h1234_5678, 3, 0, 0, 32'h1234_5678);
      tbl[5] = mk(0, 6'h11, 32'h0,         4'h0,     3,   0, 32'h0000_CAFE, 6, 0, 0, 32'h0000_CAFE);
      tbl[6] = mk(1, 6'h22, 32'hA5A5_5A5A, 4'h3,     4,   0, 32'h0,         6, 1, 1, 32'h0);
      tbl[7] = mk(1, 6'h01, 32'h7654_3210, 4'h5,     1,   1, 32'hFFFF_FFFF, 4, 1, 0, 32'h0);

      repeat (2) @(negedge clk);
      chk("reset.ctl", {apb_psel, apb_penable, apb_pwrite, rsp_vld, rsp_err, rsp_tmo, req_rdy}, 7'b0000001);
      chk("reset.rdat", rsp_rdat, 32'h0);
      chk("reset.paddr", apb_paddr, '0);
      chk("reset.pwdata", apb_pwdata, 32'h0);
      chk("reset.pwstrb", apb_pwstrb, 4'h0);
      chk("pprot", apb_pprot, PROT);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         do_xfer(tbl[i], 1'b0, $sformatf("tbl%0d", i));
         @(negedge clk);
         chk($sformatf("tbl%0d.pulse", i), rsp_vld, 1'b0);
      end

      // Four writes with req_vld held high: each starts in the previous response cycle
      for (int i = 0; i < 4; i++) begin
         x = mk(1, AW'(6'h30 + i), 32'h1000_0000 * (i + 1), 4'(i + 9), 0, 0, 32'h0, 3, 0, 0, 32'h0);
         do_xfer(x, 1'b1, $sformatf("b2b%0d", i));
      end
      req_vld = 1'b0;
      @(negedge clk);
      chk("b2b.end", {rsp_vld, apb_psel}, 2'b00);

      // Reset in the middle of an ACCESS phase
      chk("rst.rdy", req_rdy, 1'b1);
      req_vld = 1'b1; req_wen = 1'b0; req_addr = 6'h2A;
      @(negedge clk);
      req_vld = 1'b0; apb_pready = 1'b0;
      @(negedge clk);
      chk("rst.access", {apb_psel, apb_penable}, 2'b11);
      #2 rst = 1'b1;
      #1 chk("rst.drop", {apb_psel, apb_penable, rsp_vld}, 3'b000);
      @(negedge clk);
      chk("rst.held", {apb_psel, rsp_vld}, 2'b00);
      rst = 1'b0;
      chk("rst.rdy_after", req_rdy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst.quiet%0d", i), {rsp_vld, apb_psel}, 2'b00);
      end
      x = mk(0, 6'h2A, 32'h0, 4'h0, 1, 0, 32'h0BAD_F00D, 4, 0, 0, 32'h0BAD_F00D);
      do_xfer(x, 1'b0, "rst.next");
      @(negedge clk);

      // Randomized transfers against the reference model
      for (int i = 0; i < 40; i++) begin
         bit hold;
         x.wen = 1'($urandom); x.addr = AW'($urandom); x.wdat = $urandom; x.strb = 4'($urandom);
         x.waits = int'($urandom_range(0, 6)); x.err = 1'($urandom); x.rdat = $urandom;
         x = model(x);
         hold = 1'($urandom);
         do_xfer(x, hold, $sformatf("rnd%0d", i));
         if ($urandom_range(0, 1) == 1) begin
            req_vld = 1'b0;
            @(negedge clk);
            chk($sformatf("rnd%0d.pulse", i), rsp_vld, 1'b0);
         end
      end
      req_vld = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/cmm_hst2apb.md
Name: cmm_hst2apb

Overview:
- APB4 requester. It is the initiating end of the host-register APB link; the existing APB-to-host bridge is the completer end.
- Converts a simple valid/ready host request (read or write, one word) into one APB setup/access transfer, then returns one response pulse.
- Used by test-control and configuration sequencers to drive register blocks (calc-control registers, interrupt registers) over APB.
- Includes a programmable wait-state timeout so that a hung completer cannot stall the requester.

Parameters:
- C_AW, 6, APB address width.
- C_TMO, 255, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.
- C_TMO_W, 8, timeout counter width; must satisfy C_TMO < 2**C_TMO_W.
- C_PROT, 3'b000, constant driven on apb_pprot.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- req_vld  in  1  host request valid.
- req_rdy  out  1  block can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  C_AW  register address.
- req_wdat  in  32  write data.
- req_strb  in  4  write byte strobes.
- rsp_vld  out  1  one-cycle response pulse.
- rsp_rdat  out  32  read data; 0 for writes and aborts.
- rsp_err  out  1  pslverr seen, or timeout.
- rsp_tmo  out  1  transfer aborted by timeout.
- apb_psel  out  1  APB select.
- apb_penable  out  1  APB enable.
- apb_pwrite  out  1  APB write.
- apb_pprot  out  3  APB protection, driven to C_PROT.
- apb_paddr  out  C_AW  APB address.
- apb_pwdata  out  32  APB write data.
- apb_pwstrb  out  4  APB write strobes.
- apb_pready  in  1  completer ready.
- apb_prdata  in  32  completer read data.
- apb_pslverr  in  1  completer error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered except req_rdy, which is (state==IDLE).
- Reset (async, while rst=1): state=IDLE. psel, penable, pwrite, paddr, pwdata, pwstrb = 0. rsp_vld, rsp_rdat, rsp_err, rsp_tmo = 0. Timeout counter = 0. A reset mid-transfer drops psel/penable at once and generates no response.
- IDLE -> SETUP on req_vld&req_rdy (cycle T). In this cycle the block captures wen, addr and wdat. For writes it captures strb; for reads pwstrb is forced to 4'b0000. pwdata is zeroed for reads.
- SETUP (T+1): psel=1, penable=0. Always advances to ACCESS. pready is ignored in SETUP.
- ACCESS (T+2 onward): psel=1, penable=1. paddr, pwrite, pwdata and pwstrb are held stable.
  - If pready=1: go to IDLE. Next cycle rsp_vld=1, rsp_err=pslverr, rsp_tmo=0.
  - rsp_rdat = prdata for a read, 0 for a write. For a read with pslverr=1, rsp_rdat is still passed through.
- Minimum latency: accept at T, response at T+3. Each extra pready-low cycle adds 1.
- Timeout: the counter clears on entering ACCESS and increments on each ACCESS cycle with pready=0.
  - If C_TMO!=0 and the counter reaches C_TMO with pready still 0, the block aborts on that edge: next cycle psel=penable=0, rsp_vld=1, rsp_err=1, rsp_tmo=1, rsp_rdat=0.
  - If pready=1 arrives in the same cycle the counter hits C_TMO, normal completion wins.
- Response has no backpressure; rsp_vld lasts exactly 1 cycle.
- req_rdy=1 in the IDLE cycle that carries rsp_vld. Back-to-back requests therefore cost one psel-low gap cycle, giving a 3-cycle minimum period.
- Request fields are sampled only on acceptance. Changes to them while the block is busy are ignored.
- After the response, psel=0 and penable=0. paddr, pwdata and pwrite keep their last values; they are not required to be zeroed.

Decomposition:
- Package cmm_hst2apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS), 2-bit;
  - the response code constants RSP_OK, RSP_SLVERR, RSP_TMO, for bench scoreboard use;
  - the APB4 strobe-all constant 4'hF.
- One natural sub-module, cmm_tmo_cnt: a parameterized clear/increment/hit counter, reusable for the AXI requester timeout.

Test Plan:
- Write addr 6'h04, wdat 32'h0000_0001, strb 4'hF, completer pready=1 at first ACCESS -> psel at T+1, penable at T+2, rsp_vld at T+3, rsp_err=0, rsp_rdat=0.
- Read addr 6'h10, completer inserts 3 wait states, prdata=32'h0000_00A5 -> paddr held 5 ACCESS-stable cycles total span, rsp_vld at T+6, rsp_rdat=32'hA5, pwstrb=0 throughout.
- Read with pslverr=1, prdata=32'hDEAD_BEEF -> rsp_err=1, rsp_tmo=0, rsp_rdat=32'hDEADBEEF.
- Timeout: C_TMO=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_tmo=1, rsp_rdat=0. Next request is accepted normally. Corner case: pready=1 on the 4th cycle -> normal completion.
- Back-to-back: req_vld held high for 4 writes with zero wait -> 4 responses at 3-cycle spacing, one psel-low cycle between transfers, strobes/data match each request.
- Assert rst during ACCESS of a read -> psel and penable drop combinationally, no rsp_vld, req_rdy=1 after rst deasserts, next read completes correctly.
